// File: rtl/rx_packet_assembler.sv
// rx_packet_assembler: oversampling UART receive front end.
// Synchronizes RxD, finds the start bit, samples an 11-bit frame at bit centres
// and presents it as a parallel packet followed by a one-clock completion pulse.
module rx_packet_assembler #(
    parameter int unsigned SAMPLE_DIV = 326,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Rx_EN,
    input  logic        RxD,
    output logic [10:0] packet,
    output logic        packet_completion,
    output logic        Rx_FERROR,
    output logic        Rx_BUSY
);

    localparam int unsigned DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned OS_W    = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FRAME_W = 11;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_STOP = BIT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Registered state
    logic                r_sync1;
    logic                r_sync2;
    logic [DIV_W-1:0]    r_div_cnt;
    state_t              r_state;
    logic [OS_W-1:0]     r_os_cnt;
    logic [BIT_W-1:0]    r_bit_idx;
    logic [FRAME_W-1:0]  r_shift;
    logic [FRAME_W-1:0]  r_packet;
    logic                r_ferror;
    logic                r_completion;
    logic                r_busy;

    // Combinational next values
    logic                w_rxd_s;
    logic                w_tick;
    state_t              w_state_nx;
    logic [OS_W-1:0]     w_os_nx;
    logic [BIT_W-1:0]    w_bit_nx;
    logic [FRAME_W-1:0]  w_shift_nx;
    logic [FRAME_W-1:0]  w_merged;
    logic [FRAME_W-1:0]  w_packet_nx;
    logic                w_ferror_nx;

    assign w_rxd_s = r_sync2;
    assign w_tick  = Rx_EN && (r_div_cnt == DIV_LAST);

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_sync2 <= r_sync1;
        end
    end

    // Sample-tick divider, parked at zero while the receiver is disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (!Rx_EN || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= DIV_W'(r_div_cnt + DIV_W'(1));
        end
    end

    // Shift register with the current sample merged in at the active bit index
    always_comb begin
        w_merged = r_shift;
        for (int unsigned i = 0; i < FRAME_W; i++) begin
            if (r_bit_idx == BIT_W'(i)) begin
                w_merged[i] = w_rxd_s;
            end
        end
    end

    // Next-state and datapath decode for the frame receiver
    always_comb begin
        w_state_nx  = r_state;
        w_os_nx     = r_os_cnt;
        w_bit_nx    = r_bit_idx;
        w_shift_nx  = r_shift;
        w_packet_nx = r_packet;
        w_ferror_nx = r_ferror;

        unique case (r_state)
            S_IDLE: begin
                if (w_tick && !w_rxd_s) begin
                    w_state_nx = S_START;
                    w_os_nx    = '0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_os_cnt == OS_MID) begin
                        w_os_nx = '0;
                        if (w_rxd_s) begin
                            // Line back high at the start-bit centre: glitch, ignore it
                            w_state_nx = S_IDLE;
                        end else begin
                            w_state_nx    = S_DATA;
                            w_bit_nx      = BIT_W'(1);
                            w_shift_nx[0] = 1'b0;
                        end
                    end else begin
                        w_os_nx = OS_W'(r_os_cnt + OS_W'(1));
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_os_cnt == OS_LAST) begin
                        w_os_nx    = '0;
                        w_shift_nx = w_merged;
                        if (r_bit_idx == BIT_STOP) begin
                            w_packet_nx = w_merged;
                            w_ferror_nx = ~w_rxd_s;
                            w_state_nx  = S_DONE;
                        end else begin
                            w_bit_nx = BIT_W'(r_bit_idx + BIT_W'(1));
                        end
                    end else begin
                        w_os_nx = OS_W'(r_os_cnt + OS_W'(1));
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Disable aborts any frame in flight; delivered packet and error flag survive
        if (!Rx_EN) begin
            w_state_nx = S_IDLE;
            w_os_nx    = '0;
            w_bit_nx   = '0;
        end
    end

    // State, counters and shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_os_cnt  <= w_os_nx;
            r_bit_idx <= w_bit_nx;
            r_shift   <= w_shift_nx;
        end
    end

    // Output registers; completion trails the packet load by one clock
    always_ff @(posedge clk) begin
        if (reset) begin
            r_packet     <= '0;
            r_ferror     <= 1'b0;
            r_completion <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_packet     <= w_packet_nx;
            r_ferror     <= w_ferror_nx;
            r_completion <= Rx_EN && (r_state == S_DONE);
            r_busy       <= (w_state_nx != S_IDLE);
        end
    end

    assign packet            = r_packet;
    assign packet_completion = r_completion;
    assign Rx_FERROR         = r_ferror;
    assign Rx_BUSY           = r_busy;

endmodule
